piso_serial_tx: RTL

//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word via valid/ready handshake,

---
 rtl/piso_serial_tx.sv | 106 ++++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake and
// shifts it out MSB first, one bit per clk. Define PISO_SERIAL_TX_PARITY_EN to append an even-parity bit.
module piso_serial_tx #(
  parameter int   WIDTH      = 5,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             sout_nxt, sout_valid_nxt, busy_nxt, done_nxt;
  logic             finish;

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      sout       <= sout_nxt;
      sout_valid <= sout_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // The word is rotated rather than shifted so every captured bit stays live; rotation
  // also preserves the XOR of the word, so parity can be taken at the end of SHIFT.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    cnt_nxt        = cnt;
    sout_nxt       = sout;
    sout_valid_nxt = sout_valid;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    finish         = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          shreg_nxt      = data_in;
          cnt_nxt        = '0;
          sout_nxt       = data_in[WIDTH-1];
          sout_valid_nxt = 1'b1;
          busy_nxt       = 1'b1;
          state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef PISO_SERIAL_TX_PARITY_EN
          sout_nxt  = ^shreg;
          state_nxt = PARITY;
`else
          finish    = 1'b1;
`endif
        end else begin
          sout_nxt  = shreg[WIDTH-2];
          shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
          cnt_nxt   = cnt + CW'(1);
        end
      end
`ifdef PISO_SERIAL_TX_PARITY_EN
      PARITY: finish = 1'b1;
`endif
      default: state_nxt = IDLE;
    endcase

    if (finish) begin
      state_nxt      = IDLE;
      sout_nxt       = IDLE_LEVEL;
      sout_valid_nxt = 1'b0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b1;
    end
  end

endmodule
